// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: FSM encoding,
// default widths and a one-hot to index helper.
package axis_arb_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_CNT_WIDTH  = 16;
   localparam int unsigned MAX_SRC        = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_e;

   // Index of the set bit in a one-hot vector (0 when the vector is empty).
   function automatic logic [2:0] onehot_idx(input logic [MAX_SRC-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_SRC; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the
// pointer, wrapping modulo NUM_SRC.
module rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_SRC-1:0] pick_o,
   output logic               valid_o
);

   int unsigned      pos;
   logic [PTR_W-1:0] sel;

   // Scan from the pointer upward; the first request found wins.
   always_comb begin
      pick_o  = '0;
      valid_o = 1'b0;
      pos     = 0;
      sel     = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         pos = 32'(ptr_i) + k;
         if (pos >= NUM_SRC) pos = pos - NUM_SRC;
         sel = PTR_W'(pos);
         if (!valid_o && req_i[sel]) begin
            pick_o[sel] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI-Stream packet arbiter in front of a shared FIFO slave port.
// Round-robin at packet granularity; a grant is held until the granted
// source's tlast beat is accepted.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic [NUM_SRC-1:0]            grant,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          pkt_count
);

   localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   arb_state_e           state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [NUM_SRC-1:0]   pick;
   logic                 pick_vld;
   logic [PTR_W-1:0]     gidx;
   logic                 eop;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req_i   (s_axis_tvalid),
      .ptr_i   (ptr_q),
      .pick_o  (pick),
      .valid_o (pick_vld)
   );

   assign gidx = PTR_W'(onehot_idx(MAX_SRC'(grant_q)));

   // Forwarding mux; grant is zero outside XFER, so everything reads 0 when idle.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_q[i]) begin
            m_axis_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid = s_axis_tvalid[i];
            m_axis_tlast  = s_axis_tlast[i];
         end
      end
   end

   assign s_axis_tready = grant_q & {NUM_SRC{m_axis_tready}};
   assign eop           = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Next-state: latch a pick in IDLE, release and advance pointer on tlast.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (eop) begin
               grant_d = '0;
               ptr_d   = (gidx == PTR_W'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant     = grant_q;
   assign busy      = (state_q == ST_XFER);
   assign pkt_count = cnt_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter (4 sources, 32-bit data,
// 4-bit packet counter so counter wrap is reachable).
module tb_axis_packet_arbiter;

   localparam int unsigned NS = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   logic               aclk = 1'b0;
   logic               aresetn = 1'b0;
   logic [NS*DW-1:0]   s_axis_tdata;
   logic [NS-1:0]      s_axis_tvalid;
   logic [NS-1:0]      s_axis_tlast;
   logic [NS-1:0]      s_axis_tready;
   logic [DW-1:0]      m_axis_tdata;
   logic               m_axis_tvalid;
   logic               m_axis_tlast;
   logic               m_axis_tready;
   logic [NS-1:0]      grant;
   logic               busy;
   logic [CW-1:0]      pkt_count;

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   axis_packet_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_SRC    (NS),
      .CNT_WIDTH  (CW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .grant         (grant),
      .busy          (busy),
      .pkt_count     (pkt_count)
   );

   // Source stimulus: each source offers len beats of base+idx, then
   // optionally repeats rep more packets with base advanced by 16.
   logic [31:0] base [NS];
   int unsigned len  [NS];
   int unsigned idx  [NS];
   int unsigned rep  [NS];
   logic [NS-1:0] hs;
   logic          fifo_rdy;
   int            cyc;

   logic [31:0]   obs_data [$];
   logic          obs_last [$];
   logic [NS-1:0] obs_gnt  [$];
   int            obs_cyc  [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         if (idx[i] < len[i]) begin
            s_axis_tvalid[i]          = 1'b1;
            s_axis_tdata[i*DW +: DW]  = base[i] + idx[i];
            s_axis_tlast[i]           = (idx[i] == len[i] - 1);
         end else begin
            s_axis_tvalid[i]          = 1'b0;
            s_axis_tdata[i*DW +: DW]  = '0;
            s_axis_tlast[i]           = 1'b0;
         end
      end
      m_axis_tready = fifo_rdy;
   endtask

   // One clock: advance sources on last cycle's handshakes, drive, then sample.
   task automatic step();
      @(posedge aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (hs[i]) begin
            idx[i]++;
            if (idx[i] == len[i] && rep[i] > 0) begin
               rep[i]--;
               idx[i]  = 0;
               base[i] = base[i] + 32'd16;
            end
         end
      end
      drive();
      #1;
      cyc++;
      hs = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
         obs_data.push_back(m_axis_tdata);
         obs_last.push_back(m_axis_tlast);
         obs_gnt.push_back(grant);
         obs_cyc.push_back(cyc);
      end
   endtask

   task automatic start_src(input int s, input logic [31:0] b, input int unsigned l, input int unsigned r);
      base[s] = b;
      len[s]  = l;
      idx[s]  = 0;
      rep[s]  = r;
   endtask

   task automatic clear_obs();
      obs_data.delete();
      obs_last.delete();
      obs_gnt.delete();
      obs_cyc.delete();
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      for (int i = 0; i < NS; i++) start_src(i, 32'h0, 0, 0);
      hs       = '0;
      fifo_rdy = 1'b1;
      drive();
      repeat (2) @(posedge aclk);
      #5;
      aresetn = 1'b1;
      clear_obs();
   endtask

   initial begin
      int   bad;
      int   maxp;
      logic [31:0] exp_d;

      cyc      = 0;
      hs       = '0;
      fifo_rdy = 1'b1;
      for (int i = 0; i < NS; i++) start_src(i, 32'h0, 0, 0);

      // Reset with every source requesting: outputs must stay gated.
      aresetn       = 1'b0;
      s_axis_tvalid = '1;
      s_axis_tlast  = '1;
      s_axis_tdata  = {NS{32'hDEADBEEF}};
      m_axis_tready = 1'b1;
      #12;
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_pkt", 64'(pkt_count), 64'h0);
      chk("rst_mvalid", 64'(m_axis_tvalid), 64'h0);
      chk("rst_mlast", 64'(m_axis_tlast), 64'h0);
      chk("rst_mdata", 64'(m_axis_tdata), 64'h0);
      chk("rst_sready", 64'(s_axis_tready), 64'h0);

      // Test 1: source 0, 16 beats 0..15.
      do_reset();
      start_src(0, 32'h0, 16, 0);
      step();
      chk("t1_idle_grant", 64'(grant), 64'h0);
      chk("t1_idle_mvalid", 64'(m_axis_tvalid), 64'h0);
      chk("t1_idle_sready", 64'(s_axis_tready), 64'h0);
      for (int k = 0; k < 16; k++) begin
         step();
         chk("t1_grant", 64'(grant), 64'h1);
         chk("t1_busy", 64'(busy), 64'h1);
         chk("t1_mvalid", 64'(m_axis_tvalid), 64'h1);
         chk("t1_mdata", 64'(m_axis_tdata), 64'(k));
         chk("t1_mlast", 64'(m_axis_tlast), 64'(k == 15));
         chk("t1_sready", 64'(s_axis_tready), 64'h1);
      end
      step();
      chk("t1_end_grant", 64'(grant), 64'h0);
      chk("t1_end_busy", 64'(busy), 64'h0);
      chk("t1_end_pkt", 64'(pkt_count), 64'h1);

      // Test 2: sources 0 and 1 request together, 4 beats each.
      do_reset();
      start_src(0, 32'hA0, 4, 0);
      start_src(1, 32'hB0, 4, 0);
      bad = 0;
      for (int t = 0; t < 30 && obs_data.size() < 8; t++) begin
         step();
         if (grant == 4'b0001 && s_axis_tready[1]) bad = 1;
      end
      step();
      chk("t2_nbeats", 64'(obs_data.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
         exp_d = (k < 4) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k - 4);
         if (k < obs_data.size()) begin
            chk("t2_data", 64'(obs_data[k]), 64'(exp_d));
            chk("t2_last", 64'(obs_last[k]), 64'(k == 3 || k == 7));
         end
      end
      if (obs_cyc.size() == 8) chk("t2_bubble", 64'(obs_cyc[4] - obs_cyc[3]), 64'd2);
      chk("t2_src1_not_acked", 64'(bad), 64'h0);
      chk("t2_pkt", 64'(pkt_count), 64'h2);

      // Test 3: all four sources offer two 2-beat packets back to back.
      do_reset();
      for (int i = 0; i < NS; i++) start_src(i, 32'(i) * 32'h100, 2, 1);
      for (int t = 0; t < 60 && obs_data.size() < 16; t++) step();
      step();
      chk("t3_nbeats", 64'(obs_data.size()), 64'd16);
      for (int k = 0; k < 16; k++) begin
         if (k < obs_data.size()) begin
            chk("t3_grant", 64'(obs_gnt[k]), 64'(4'b0001 << ((k / 2) % 4)));
            chk("t3_data", 64'(obs_data[k]),
                64'(((k / 2) % 4) * 256 + ((k / 2) / 4) * 16 + (k % 2)));
            chk("t3_last", 64'(obs_last[k]), 64'(k % 2));
         end
      end
      chk("t3_pkt", 64'(pkt_count), 64'h8);
      chk("t3_idle", 64'(busy), 64'h0);

      // Test 4: source 2, 8 beats, 5 stalled cycles on beat 3.
      do_reset();
      start_src(2, 32'h20, 8, 0);
      repeat (4) step();
      fifo_rdy = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         chk("t4_stall_mvalid", 64'(m_axis_tvalid), 64'h1);
         chk("t4_stall_mdata", 64'(m_axis_tdata), 64'h23);
         chk("t4_stall_sready", 64'(s_axis_tready), 64'h0);
         chk("t4_stall_grant", 64'(grant), 64'h4);
      end
      fifo_rdy = 1'b1;
      for (int t = 0; t < 20 && obs_data.size() < 8; t++) step();
      step();
      chk("t4_nbeats", 64'(obs_data.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < obs_data.size()) begin
            chk("t4_data", 64'(obs_data[k]), 64'(32'h20 + 32'(k)));
            chk("t4_last", 64'(obs_last[k]), 64'(k == 7));
         end
      end
      chk("t4_pkt", 64'(pkt_count), 64'h1);

      // Test 5: reset mid-packet, then pointer must be back at source 0.
      do_reset();
      start_src(2, 32'h2F, 1, 0);
      step();
      step();
      start_src(1, 32'h10, 10, 0);
      step();
      chk("t5_pre_pkt", 64'(pkt_count), 64'h1);
      chk("t5_pre_busy", 64'(busy), 64'h0);
      repeat (6) step();
      chk("t5_mid_grant", 64'(grant), 64'h2);
      chk("t5_mid_mdata", 64'(m_axis_tdata), 64'h15);
      aresetn = 1'b0;
      #1;
      chk("t5_async_grant", 64'(grant), 64'h0);
      chk("t5_async_busy", 64'(busy), 64'h0);
      chk("t5_async_mvalid", 64'(m_axis_tvalid), 64'h0);
      chk("t5_async_pkt", 64'(pkt_count), 64'h0);
      chk("t5_async_sready", 64'(s_axis_tready), 64'h0);
      do_reset();
      start_src(0, 32'h0A, 1, 0);
      start_src(3, 32'h3A, 1, 0);
      step();
      chk("t5_post_idle", 64'(grant), 64'h0);
      step();
      chk("t5_first_grant", 64'(grant), 64'h1);
      chk("t5_first_data", 64'(m_axis_tdata), 64'h0A);
      step();
      chk("t5_bubble", 64'(grant), 64'h0);
      step();
      chk("t5_second_grant", 64'(grant), 64'h8);
      chk("t5_second_data", 64'(m_axis_tdata), 64'h3A);
      step();
      chk("t5_pkt", 64'(pkt_count), 64'h2);

      // Test 6: 16 single-beat packets wrap the 4-bit counter.
      do_reset();
      start_src(0, 32'h0, 1, 15);
      maxp = 0;
      for (int t = 0; t < 80 && obs_data.size() < 16; t++) begin
         step();
         if (int'(pkt_count) > maxp) maxp = int'(pkt_count);
      end
      step();
      chk("t6_nbeats", 64'(obs_data.size()), 64'd16);
      chk("t6_max_pkt", 64'(maxp), 64'd15);
      chk("t6_wrap_pkt", 64'(pkt_count), 64'h0);
      chk("t6_idle", 64'(busy), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
